demux_scan_ctrl: RTL and testbench
==================================

// Module: demux_scan_ctrl
// PURPOSE
//  Upstream driver for the 1:8 demux stage. Takes a valid/ready bit stream
//  and steps the demux select S through the enabled channels (scan mode) or
//  one addressed channel. Drives demux data I for DWELL cycles per channel.
//  Pulses frame_done when the frame completes.
// PARAMETERS
//  NCH    8  number of demux outputs (power of two)
//  SEL_W  3  select width, equals log2(NCH)
//  DWELL  6  cycles each channel's bit is held on I (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      async active-high reset
//  start       in   1      begin frame; sampled only in IDLE
//  abort       in   1      sync abort; returns to IDLE next edge
//  mode        in   1      0 = scan enabled channels, 1 = single addressed
//  addr        in   SEL_W  channel for mode=1; latched at start
//  ch_mask     in   NCH    channel enables for mode=0; latched at start
//  in_valid    in   1      upstream bit valid
//  in_bit      in   1      upstream data bit
//  in_ready    out  1      = (state==WAIT) & ~abort, combinational
//  I           out  1      registered data to demux
//  S           out  SEL_W  registered select to demux
//  busy        out  1      high in any state except IDLE
//  frame_done  out  1      one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset (async): I=0, S=0, busy=0, frame_done=0, state=IDLE, dwell cnt=0.
//  States: IDLE -> WAIT -> HOLD -> [GUARD] -> WAIT | DONE -> IDLE.
//  IDLE: on start, latch mode, addr and ch_mask.
//   - mode=1: ch=addr, go to WAIT.
//   - mode=0: ch = lowest set bit of mask, go to WAIT.
//   - mode=0, mask==0: go to DONE directly. No data is accepted.
//  WAIT: in_ready=1, I=0, S holds its last value.
//   - On in_valid & in_ready: next edge I<=in_bit, S<=ch, cnt<=DWELL-1, go HOLD.
//  HOLD: I and S stable. cnt decrements each cycle.
//   - At cnt==0, next edge sets I<=0.
//   - If a higher enabled channel exists (mode=0), ch <= next enabled
//     index, then go WAIT (or GUARD). Otherwise go DONE.
//  DONE: frame_done=1 for exactly one cycle, busy=0 next, then IDLE.
//  Latency: handshake at edge N puts I/S valid in cycles N+1..N+DWELL.
//   I returns to 0 in cycle N+DWELL+1.
//  Channel index never wraps. A scan ends after the highest enabled channel.
//  A set channel is always visited once per frame.
//  start while busy: ignored. ch_mask/addr changes mid-frame: no effect.
//  abort in any state: next edge I=0, busy=0, state=IDLE, no frame_done.
//   S keeps its last value. abort wins over a same-cycle handshake; no bit
//   is consumed, because in_ready is low that cycle.
//  abort in IDLE: no-op. start and abort in the same IDLE cycle: abort wins.
//  in_valid in non-WAIT states: ignored; upstream must hold its bit.
//  At most one demux output is ever driven: I=0 whenever S changes.
// CONFIGURATION
//  GUARD_EN defined: one GUARD cycle after each HOLD before the next WAIT.
//   During GUARD: I=0, S unchanged, in_ready=0. Gives break-before-make
//   on the demux outputs.
//   Not inserted before DONE.
//  GUARD_EN undefined: HOLD goes straight to WAIT; GUARD state is absent.
// TESTING
//  1 Reset mid-HOLD (I=1,S=3): assert rst -> I=0,S=0,busy=0 immediately.
//  2 mode=0, mask=8'hFF, 8 bits 10110011 all valid=1, DWELL=6 ->
//    S steps 0..7, each held 6 cycles, I follows the bits.
//    frame_done pulses once; 8 handshakes total.
//  3 mode=0, mask=8'b1010_0100 -> S visits only 2,5,7, then frame_done.
//    Also mask=0 -> frame_done one cycle after the start edge, no handshake.
//  4 mode=1, addr=6, bit=1 -> S=6, I=1 for 6 cycles, then I=0 and frame_done.
//    A second start while busy is ignored.
//  5 abort in the same cycle as in_valid during WAIT ->
//    no bit consumed, IDLE, I=0, no frame_done.
//  6 GUARD_EN defined, mask=8'h03 -> one cycle with I=0 and in_ready=0
//    between ch0 and ch1. Absent when GUARD_EN is undefined.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: feeds a 1:NCH demux with data I and select S, scanning the enabled
// channels or one addressed channel. Define GUARD_EN for a break-before-make cycle between channels.
module demux_scan_ctrl #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [SEL_W-1:0] addr,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             I,
    output logic [SEL_W-1:0] S,
    output logic             busy,
    output logic             frame_done
);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
`ifdef GUARD_EN
        GUARD = 3'd4,
`endif
        DONE  = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             mode_q, mode_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             i_d;
    logic [SEL_W-1:0] s_d;
    logic             busy_d, fd_d;
    logic [SEL_W:0]   first_en, next_en;

    // Lowest enabled channel above cur (or at cur when incl); returns {found, index}.
    function automatic logic [SEL_W:0] next_enabled(input logic [NCH-1:0]   mask,
                                                    input logic [SEL_W-1:0] cur,
                                                    input logic             incl);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask[i] && ((SEL_W'(i) > cur) || (incl && (SEL_W'(i) == cur)))) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    assign in_ready = (state_q == WAIT) && !abort;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        i_d      = I;
        s_d      = S;
        first_en = next_enabled(ch_mask, '0, 1'b1);
        next_en  = next_enabled(mask_q, ch_q, 1'b0);

        if (abort) begin
            state_d = IDLE;
            i_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d = mode;
                        mask_d = ch_mask;
                        if (mode) begin
                            ch_d    = addr;
                            state_d = WAIT;
                        end else if (first_en[SEL_W]) begin
                            ch_d    = first_en[SEL_W-1:0];
                            state_d = WAIT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                WAIT: begin
                    i_d = 1'b0;
                    if (in_valid) begin
                        i_d     = in_bit;
                        s_d     = ch_q;
                        cnt_d   = CNT_LOAD;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        i_d = 1'b0;
                        // Scan moves upward only; single-channel frames end after one dwell
                        if (!mode_q && next_en[SEL_W]) begin
                            ch_d = next_en[SEL_W-1:0];
`ifdef GUARD_EN
                            state_d = GUARD;
`else
                            state_d = WAIT;
`endif
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`ifdef GUARD_EN
                GUARD: begin
                    i_d     = 1'b0;
                    state_d = WAIT;
                end
`endif
                DONE: begin
                    i_d     = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    i_d     = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        fd_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            mode_q     <= 1'b0;
            mask_q     <= '0;
            cnt_q      <= '0;
            I          <= 1'b0;
            S          <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            I          <= i_d;
            S          <= s_d;
            busy       <= busy_d;
            frame_done <= fd_d;
        end
    end
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl: frame table, hand-written abort/reset sequences and
// random frames checked against a channel-schedule model.
module tb_demux_scan_ctrl;
    localparam int unsigned NCH   = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DWELL = 6;

    logic             clk = 1'b0;
    logic             rst, start, abort, mode, in_valid, in_bit;
    logic [SEL_W-1:0] addr;
    logic [NCH-1:0]   ch_mask;
    logic             in_ready, I, busy, frame_done;
    logic [SEL_W-1:0] S;

    int tests = 0;
    int fails = 0;
    int hs_mon = 0;
    int fd_mon = 0;
    logic [SEL_W-1:0] last_s;
    logic [NCH-1:0]   visited;
    logic [7:0]       obs_bits;

    demux_scan_ctrl #(.NCH(NCH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .addr(addr), .ch_mask(ch_mask), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .I(I), .S(S), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && in_valid && in_ready) hs_mon++;
    always @(negedge clk) if (frame_done) fd_mon++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic noise();
        start   = 1'($urandom_range(0, 1));
        mode    = 1'($urandom_range(0, 1));
        addr    = SEL_W'($urandom);
        ch_mask = NCH'($urandom);
    endtask

    // One frame from IDLE; expectation built from the visit list and the dwell timing.
    task automatic run_frame(input logic m, input logic [SEL_W-1:0] a, input logic [NCH-1:0] mk,
                             input logic [7:0] bits, input int vpct, input string tag);
        int  chl[$];
        int  wait_n;
        logic hs;
        visited  = '0;
        obs_bits = '0;
        if (m) chl.push_back(int'(a));
        else for (int i = 0; i < int'(NCH); i++) if (mk[i]) chl.push_back(i);

        start = 1'b1; mode = m; addr = a; ch_mask = mk; in_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < chl.size(); k++) begin
            wait_n = 0;
            hs = 1'b0;
            while (!hs && wait_n < 60) begin
                noise();
                in_valid = ($urandom_range(1, 100) <= vpct);
                in_bit   = in_valid ? bits[7-k] : 1'($urandom_range(0, 1));
                #1;
                check({tag, "/wait_I"}, I, 0);
                check({tag, "/wait_S"}, S, last_s);
                check({tag, "/wait_busy"}, busy, 1);
                check({tag, "/wait_fd"}, frame_done, 0);
                check({tag, "/wait_rdy"}, in_ready, 1);
                hs = in_valid;
                @(posedge clk); #1;
                wait_n++;
            end
            if (!hs) begin
                tests++; fails++;
                $display("FAIL %s/handshake_timeout: got none expected one within 60 cycles", tag);
                return;
            end
            for (int d = 0; d < int'(DWELL); d++) begin
                noise();
                in_valid = 1'($urandom_range(0, 1));
                in_bit   = 1'($urandom_range(0, 1));
                #1;
                check({tag, "/hold_I"}, I, bits[7-k]);
                check({tag, "/hold_S"}, S, chl[k]);
                check({tag, "/hold_busy"}, busy, 1);
                check({tag, "/hold_fd"}, frame_done, 0);
                check({tag, "/hold_rdy"}, in_ready, 0);
                if (d == 0) begin
                    visited[S]   = 1'b1;
                    obs_bits[7-k] = I;
                end
                @(posedge clk); #1;
            end
            last_s = SEL_W'(chl[k]);
`ifdef GUARD_EN
            if (k + 1 < chl.size()) begin
                noise();
                #1;
                check({tag, "/guard_I"}, I, 0);
                check({tag, "/guard_S"}, S, last_s);
                check({tag, "/guard_rdy"}, in_ready, 0);
                check({tag, "/guard_busy"}, busy, 1);
                @(posedge clk); #1;
            end
`endif
        end
        start = 1'b0; in_valid = 1'b0;
        #1;
        check({tag, "/done_fd"}, frame_done, 1);
        check({tag, "/done_busy"}, busy, 1);
        check({tag, "/done_I"}, I, 0);
        check({tag, "/done_rdy"}, in_ready, 0);
        check({tag, "/done_S"}, S, last_s);
        @(posedge clk); #1;
        check({tag, "/idle_fd"}, frame_done, 0);
        check({tag, "/idle_busy"}, busy, 0);
        check({tag, "/idle_I"}, I, 0);
    endtask

    typedef struct {
        logic             m;
        logic [SEL_W-1:0] a;
        logic [NCH-1:0]   mk;
        logic [7:0]       bits;
        int               vpct;
        int               exp_hs;
        logic [NCH-1:0]   exp_vis;
        logic [7:0]       exp_bits;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int hs0, fd0;
        vecs[0] = '{1'b0, 3'd0, 8'hFF, 8'b1011_0011, 100, 8, 8'hFF, 8'b1011_0011};
        vecs[1] = '{1'b0, 3'd0, 8'hA4, 8'b1011_1111, 100, 3, 8'hA4, 8'b1010_0000};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 8'hFF,        100, 0, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 3'd6, 8'h00, 8'b1000_0000, 100, 1, 8'h40, 8'b1000_0000};
        vecs[4] = '{1'b1, 3'd0, 8'hFF, 8'b0111_1111, 100, 1, 8'h01, 8'h00};
        vecs[5] = '{1'b0, 3'd0, 8'h80, 8'b1000_0000, 100, 1, 8'h80, 8'b1000_0000};
        vecs[6] = '{1'b0, 3'd0, 8'h03, 8'b0100_0000, 60,  2, 8'h03, 8'b0100_0000};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; addr = '0; ch_mask = '0;
        in_valid = 1'b0; in_bit = 1'b0; last_s = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_I", I, 0);
        check("reset_S", S, 0);
        check("reset_busy", busy, 0);
        check("reset_fd", frame_done, 0);
        check("reset_rdy", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            hs0 = hs_mon; fd0 = fd_mon;
            run_frame(vecs[i].m, vecs[i].a, vecs[i].mk, vecs[i].bits, vecs[i].vpct, $sformatf("vec%0d", i));
            check($sformatf("vec%0d/handshakes", i), hs_mon - hs0, vecs[i].exp_hs);
            check($sformatf("vec%0d/visited", i), visited, vecs[i].exp_vis);
            check($sformatf("vec%0d/bits", i), obs_bits, vecs[i].exp_bits);
            check($sformatf("vec%0d/fd_pulses", i), fd_mon - fd0, 1);
        end

        // abort together with in_valid in WAIT: nothing consumed, no frame_done
        hs0 = hs_mon; fd0 = fd_mon;
        start = 1'b1; mode = 1'b1; addr = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("abw_rdy_before", in_ready, 1);
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        check("abw_rdy_low", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check("abw_busy", busy, 0);
        check("abw_I", I, 0);
        check("abw_S", S, last_s);
        @(posedge clk); #1;
        check("abw_busy_stays", busy, 0);
        check("abw_no_hs", hs_mon - hs0, 0);
        check("abw_no_fd", fd_mon - fd0, 0);

        // abort during HOLD: I drops, S kept, no frame_done
        fd0 = fd_mon;
        start = 1'b1; mode = 1'b0; ch_mask = 8'h10;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abh_I", I, 1);
        check("abh_S", S, 4);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abh_I_after", I, 0);
        check("abh_busy", busy, 0);
        check("abh_S_kept", S, 4);
        last_s = 3'd4;
        @(posedge clk); #1;
        check("abh_no_fd", fd_mon - fd0, 0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; mode = 1'b1; addr = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_rdy", in_ready, 0);

        // asynchronous reset in the middle of HOLD on channel 3
        start = 1'b1; mode = 1'b1; addr = 3'd3;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rh_I_pre", I, 1);
        check("rh_S_pre", S, 3);
        #2;
        rst = 1'b1;
        #1;
        check("rh_I", I, 0);
        check("rh_S", S, 0);
        check("rh_busy", busy, 0);
        check("rh_fd", frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_s = '0;
        @(posedge clk); #1;

        // random frames against the schedule model
        for (int r = 0; r < 30; r++) begin
            logic m;
            logic [SEL_W-1:0] a;
            logic [NCH-1:0] mk;
            int exp_n;
            m  = 1'($urandom_range(0, 1));
            a  = SEL_W'($urandom);
            mk = ($urandom_range(0, 5) == 0) ? '0 : NCH'($urandom);
            exp_n = m ? 1 : $countones(mk);
            hs0 = hs_mon; fd0 = fd_mon;
            run_frame(m, a, mk, 8'($urandom), $urandom_range(30, 100), $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d/handshakes", r), hs_mon - hs0, exp_n);
            check($sformatf("rnd%0d/visited", r), visited, m ? (NCH'(1) << a) : mk);
            check($sformatf("rnd%0d/fd_pulses", r), fd_mon - fd0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
